// File: rtl/odd_parity_pkg.sv
// rtl/odd_parity_pkg.sv - shared types, constants and parity helper for the odd-parity serial link
package odd_parity_pkg;

  localparam int DATA_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Parity bit that makes data^p == 0; the generator side uses the same helper.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] nibble);
    return ^nibble;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic 2-flop synchronizer with configurable reset value
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to resolve metastability on an asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/odd_parity_rx.sv
// rtl/odd_parity_rx.sv - serial receiver and checker for the 4-bit odd-parity frame
module odd_parity_rx
  import odd_parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  generate
    if ((CLKS_PER_BIT < 2) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
      $error("odd_parity_rx: CLKS_PER_BIT must be even and >= 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       IDX_LAST  = 2'(DATA_BITS - 1);

  logic                 rx_q;
  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 data_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic                 half_tick_d;
  logic                 bit_tick_d;

  // Pin capture flop ahead of the synchronizer; rx_s reflects rx three edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= 1'b1;
    end else begin
      rx_q <= rx;
    end
  end

  sync2 #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_q),
    .q_o (rx_s)
  );

  // Sample points: mid start bit after half a period, then once per full period.
  always_comb begin
    half_tick_d = (cnt_q == HALF_LAST);
    bit_tick_d  = (cnt_q == FULL_LAST);
  end

  // Receive FSM with bit-period counter, bit index, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (half_tick_d) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
            end else begin
              // Start bit vanished by mid-bit: treat as a glitch.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick_d) begin
            cnt_q   <= '0;
            shift_q <= {shift_q[DATA_BITS-2:0], rx_s};
            if (idx_q == IDX_LAST) begin
              state_q <= ST_PARITY;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_tick_d) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_tick_d) begin
            cnt_q        <= '0;
            data_q       <= shift_q;
            data_valid_q <= 1'b1;
            parity_err_q <= parity_of(shift_q) ^ par_q;
            frame_err_q  <= !rx_s;
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              // Line stuck low: hold off start detection until it idles high.
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_odd_parity_rx.sv
// tb/tb_odd_parity_rx.sv - scoreboard testbench for odd_parity_rx
module tb_odd_parity_rx;

  localparam int N   = 4;
  localparam int LAT = 1 + 3 + N / 2 + 6 * N;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] d;
    logic       perr;
    logic       ferr;
    int         when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  odd_parity_rx #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: frame is good when the five data+parity bits hold an even number of ones.
  function automatic exp_t model(input logic [3:0] d, input logic p, input logic stop, input int c);
    exp_t e;
    e.d    = d;
    e.perr = (($countones({d, p}) % 2) == 1);
    e.ferr = (stop == 1'b0);
    e.when = c + LAT;
    return e;
  endfunction

  // Monitor: every data_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data", data, mon_e.d);
        check("parity_err", parity_err, mon_e.perr);
        check("frame_err", frame_err, mon_e.ferr);
        check("valid_cycle", cyc, mon_e.when);
      end
    end
  end

  // Caller is #1 after a rising edge; leaves rx at the stop value.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop);
    logic [6:0] bits;
    int c;
    c    = cyc;
    sb.push_back(model(d, p, stop, c));
    bits = {1'b0, d[3], d[2], d[1], d[0], p, stop};
    for (int j = 6; j >= 0; j--) begin
      rx = bits[j];
      repeat (N) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, data, 32'd0);
    check({tag, "_valid"}, data_valid, 32'd0);
    check({tag, "_perr"}, parity_err, 32'd0);
    check({tag, "_ferr"}, frame_err, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
  endtask

  initial begin
    int hi;
    int w;
    logic [3:0] rd;
    logic       rp;
    logic       rs;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(4);

    // Good frame and bad parity frame
    send_frame(4'b1011, 1'b1, 1'b1);
    idle(4);
    send_frame(4'b0110, 1'b1, 1'b1);
    idle(6);
    check("perr_hold", parity_err, 32'd1);

    // Framing error with the line held low afterwards
    send_frame(4'b1000, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("busy_in_break", busy, 32'd1);
    idle(6);
    check("busy_after_break", busy, 32'd0);
    send_frame(4'b0011, 1'b0, 1'b1);
    idle(4);

    // Start glitch of one cycle
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check("glitch_busy_rose", (hi > 0), 32'd1);
    check("glitch_busy_short", (hi <= N / 2 + 1), 32'd1);
    @(posedge clk);
    #1;

    // Reset while idle
    rst = 1'b1;
    #2;
    check_outputs_zero("rst_idle");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);

    // Reset in the middle of the data bits
    send_frame(4'b1110, 1'b1, 1'b1);
    idle(4);
    rx = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * N) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_outputs_zero("rst_data");
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);

    // Back-to-back frames, no idle gap
    send_frame(4'b0001, 1'b1, 1'b1);
    send_frame(4'b1111, 1'b0, 1'b1);
    idle(6);

    // Randomized frames
    for (int i = 0; i < 25; i++) begin
      rd = 4'($urandom_range(0, 15));
      rp = (^rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rd, rp, rs);
      if (!rs) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        idle($urandom_range(4, 8));
      end else begin
        idle($urandom_range(0, 5));
      end
    end

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("drain", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/odd_parity_rx.md
# odd_parity_rx

Serial receiver and checker for the 4-bit odd-parity frame used across the parity blocks. It samples a single serial line, recovers the 4 data bits and the parity bit, and checks that data XOR parity is 0. It presents the word with a one-cycle valid pulse and separate parity/framing error flags. It sits at the receive end of the serial parity link, feeding downstream logic that consumes checked nibbles.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥ 2; elaboration error otherwise.
- `clk`  input  1  rising-edge clock for the whole block.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line, asynchronous to `clk`, idle high.
- `data`  output  4  last received word, `{a,b,c,d}` with `a` = MSB. Held until the next frame completes.
- `data_valid`  output  1  one-cycle pulse when a frame completes.
- `parity_err`  output  1  qualifies `data_valid`: `a^b^c^d^p` ≠ 0.
- `frame_err`  output  1  qualifies `data_valid`: stop bit sampled 0.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Frame format:** start(0), a, b, c, d, p, stop(1), in that order.
  - `p` is generated as `a^b^c^d`.
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, reset to 1. Its output is `rx_s`. The FSM uses only `rx_s`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - **IDLE:** `rx_s`=0 → START, bit counter cleared.
  - **START:** after `CLKS_PER_BIT/2` cycles, sample `rx_s`.
    - 0 → DATA, bit index 0.
    - 1 → IDLE (glitch rejected; no outputs change).
  - **DATA:** sample every `CLKS_PER_BIT` cycles and shift into the data shift register, MSB first. After the 4th sample → PARITY.
  - **PARITY:** sample `p` after `CLKS_PER_BIT` cycles → STOP.
  - **STOP:** sample after `CLKS_PER_BIT` cycles.
    - Load `data` from the shift register.
    - Pulse `data_valid`.
    - Set `parity_err` = XOR of the 4 bits and `p`.
    - Set `frame_err` = !stop.
    - Next state: IDLE if stop=1, BREAK if stop=0.
  - **BREAK:** wait until `rx_s`=1, then → IDLE. No new start is detected while the line is held low.
- **Error flag lifetime:** `parity_err` and `frame_err` are registered with `data_valid` and hold their value until the next `data_valid`.
- **Back-to-back frames:** a start bit immediately following the stop bit is accepted. There is no minimum idle time.
- **Counters:**
  - Bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide and wraps to 0 on every sample.
  - Bit index is 2 bits.

## Timing
- **Reset values:** `data`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. FSM in IDLE, synchronizer flops at 1.
- **Reset mid-frame:**
  - All outputs and state return to their reset values immediately (asynchronous).
  - The partial frame is discarded and no `data_valid` is produced.
  - After deassertion the line must go high, or be low for a fresh start, before reception resumes.
- **Latency:** E0 is the first rising edge that registers `rx`=0.
  - `rx_s`=0 after E2.
  - The FSM enters START at E3.
  - The start bit is sampled at E(3+N/2).
  - Data bit i is sampled at E(3+N/2+(i+1)N).
  - Parity is sampled at E(3+N/2+5N).
  - Stop is sampled at E(3+N/2+6N), with N = `CLKS_PER_BIT`.
  - `data_valid` is high for exactly the cycle following that stop-sample edge. For N=4 this is the cycle after E29.
- **busy:** rises at E3 and falls in the same cycle `data_valid` is high, unless the FSM enters BREAK.
- **Simultaneous events:** on the STOP sample edge the FSM returns to IDLE. A start already low in `rx_s` on that edge is detected on the next edge.

## Structure
- **Package `odd_parity_pkg`:**
  - FSM state enum.
  - `DATA_BITS` = 4.
  - `parity_of(nibble)` function, shared with the generator side.
- **Sub-module `sync2`:** generic 2-flop synchronizer with reset value parameter, instantiated once for `rx`.
- **Remaining logic:** FSM, bit-period counter, bit index, shift register and output registers live in `odd_parity_rx`.

## Test plan
- **Reset:** assert `rst` mid-idle and mid-DATA → all outputs 0, FSM IDLE, no `data_valid` from the interrupted frame.
- **Good frame, N=4:** send 0,1,0,1,1,1,1 (data 1011, p=1) → `data`=4'b1011, `data_valid` one cycle after E29, `parity_err`=0, `frame_err`=0.
- **Bad parity:** send data 0110, p=1 → `data`=4'b0110, `data_valid`=1, `parity_err`=1, `frame_err`=0.
- **Framing error:** send data 1000 with correct parity, stop=0, line held low 20 cycles → `frame_err`=1.
  - No second `data_valid` while the line is low.
  - A good frame sent after the line returns high is received correctly.
- **Start glitch:** `rx` low for 1 cycle only → no `data_valid`, `busy` returns low within N/2+1 cycles of rising.
- **Back-to-back:** frames 0001 then 1111 with no idle gap → two `data_valid` pulses exactly 7N cycles apart, correct data, no errors.
